// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared constants and types for the write-back queue that feeds the
// 32 x 32-bit register file write port.
//   DATA_W     : result width
//   ADDR_W     : register address width
//   DEPTH      : FIFO entries (power of two, >= 2)
//   REG_ZERO   : hard-wired zero register address (writes to it are dropped)
//   wb_entry_t : one pending write {add, data}
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry circular buffer of pending register writes. Besides the usual
// push/pop/count, every entry is exposed in age order (index 0 = head/oldest,
// index count-1 = tail/youngest) so the parent can run a forwarding search.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   i_push, i_add, i_data : enqueue one entry (caller guarantees not full)
//   i_pop                 : dequeue head (caller guarantees not empty)
//   o_count               : number of stored entries
//   o_ord_add/o_ord_data  : flattened entries in age order, head first
//   o_ord_vld             : per age-slot valid (slot k valid when k < count)
// -----------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [ADDR_W-1:0]          i_add,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [DEPTH*ADDR_W-1:0]    o_ord_add,
  output logic [DEPTH*DATA_W-1:0]    o_ord_data,
  output logic [DEPTH-1:0]           o_ord_vld
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // All slots must be readable at once for forwarding, so the storage is
  // register-based rather than a single-read-port RAM.
  logic [ADDR_W-1:0] r_add_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_add_mem[r_wr_ptr]  <= i_add;
      r_data_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are PW bits wide, so wrap modulo DEPTH falls out naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;

  // Rotate physical slots into age order starting at the read pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ord
    logic [PW-1:0] w_idx;
    assign w_idx = r_rd_ptr + PW'(gi);
    assign o_ord_add[gi*ADDR_W +: ADDR_W]  = r_add_mem[w_idx];
    assign o_ord_data[gi*DATA_W +: DATA_W] = r_data_mem[w_idx];
    assign o_ord_vld[gi]                   = (CW'(gi) < r_count);
  end

endmodule

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
// Buffers execute-stage results and drains them one per cycle onto the
// register file's single write port, with read-after-write forwarding for the
// two decode read addresses.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   in_valid/in_ready           : execute result handshake
//   in_add, in_data             : destination register and value
//   wb_hold                     : suppress draining this cycle
//   w_en, w_add, w_data         : registered register-file write port
//   ql_add/qr_add               : forwarding query addresses
//   ql_hit/qr_hit, ql/qr_data   : youngest pending value for each query
//   count                       : FIFO occupancy (output stage excluded)
//   empty                       : FIFO empty and no write in flight
// -----------------------------------------------------------------------------
module writeback_queue #(
  parameter int DEPTH  = wb_pkg::DEPTH,
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_add,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   wb_hold,
  output logic                   w_en,
  output logic [ADDR_W-1:0]      w_add,
  output logic [DATA_W-1:0]      w_data,
  input  logic [ADDR_W-1:0]      ql_add,
  input  logic [ADDR_W-1:0]      qr_add,
  output logic                   ql_hit,
  output logic                   qr_hit,
  output logic [DATA_W-1:0]      ql_data,
  output logic [DATA_W-1:0]      qr_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                    w_push;
  logic                    w_pop;
  logic [CW-1:0]           w_count;
  logic [DEPTH*ADDR_W-1:0] w_ord_add;
  logic [DEPTH*DATA_W-1:0] w_ord_data;
  logic [DEPTH-1:0]        w_ord_vld;

  // Ready depends on occupancy only; a pop in the same cycle does not free a
  // slot early, which keeps in_ready off the wb_hold path.
  assign in_ready = (w_count != CW'(DEPTH));
  // Writes to the zero register complete the handshake but are dropped here.
  assign w_push   = in_valid & in_ready & (in_add != ADDR_W'(REG_ZERO));
  assign w_pop    = (w_count != '0) & ~wb_hold;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_add      (in_add),
    .i_data     (in_data),
    .i_pop      (w_pop),
    .o_count    (w_count),
    .o_ord_add  (w_ord_add),
    .o_ord_data (w_ord_data),
    .o_ord_vld  (w_ord_vld)
  );

  // Output stage: address/data hold their last value when no write is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_en   <= 1'b0;
      w_add  <= '0;
      w_data <= '0;
    end else begin
      w_en <= w_pop;
      if (w_pop) begin
        w_add  <= w_ord_add[0 +: ADDR_W];
        w_data <= w_ord_data[0 +: DATA_W];
      end
    end
  end

  assign count = w_count;
  assign empty = (w_count == '0) & ~w_en;

  // Priority search: the output stage is oldest, then FIFO head..tail; each
  // later match overrides, so the youngest pending value wins.
  function automatic logic [DATA_W:0] fwd_search(
    input logic [ADDR_W-1:0]       q,
    input logic                    oen,
    input logic [ADDR_W-1:0]       oadd,
    input logic [DATA_W-1:0]       odata,
    input logic [DEPTH*ADDR_W-1:0] fadd,
    input logic [DEPTH*DATA_W-1:0] fdata,
    input logic [DEPTH-1:0]        fvld
  );
    logic [DATA_W:0] res;
    res = '0;
    if (q != ADDR_W'(REG_ZERO)) begin
      if (oen && (oadd == q)) res = {1'b1, odata};
      for (int k = 0; k < DEPTH; k++) begin
        if (fvld[k] && (fadd[k*ADDR_W +: ADDR_W] == q))
          res = {1'b1, fdata[k*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  assign {ql_hit, ql_data} = fwd_search(ql_add, w_en, w_add, w_data,
                                        w_ord_add, w_ord_data, w_ord_vld);
  assign {qr_hit, qr_data} = fwd_search(qr_add, w_en, w_add, w_data,
                                        w_ord_add, w_ord_data, w_ord_vld);

endmodule
